phys_reg_allocator: RTL and testbench
=====================================

Name: phys_reg_allocator

Overview:
- Parametrised physical-register free-list for the rename stage of the out-of-order 6502 core.
- Successor to the single fixed free_pool register held inside the decoder.
- Hands out up to ALLOC_LANES physical tags per cycle to decoder lanes, with all-or-nothing group handshake.
- Accepts up to FREE_LANES tag releases per cycle from retire, and bulk-reclaims tags on pipeline flush.

Parameters:
- PHYS_REGS, 64: total physical registers; must be a power of two, ≥ 8.
- PR_ADDR_W, 6: tag width; must equal clog2(PHYS_REGS).
- RESERVED, 2: tags 0..RESERVED-1 are permanently mapped (constant/zero regs) and never allocated or freed.
- ALLOC_LANES, 3: allocation lanes (matches decoder PIPELINES).
- FREE_LANES, 3: release lanes.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- alloc_req  in  ALLOC_LANES  per-lane request mask; lane i needs one tag
- alloc_valid  in  1  request group valid
- alloc_ready  out  1  group can be satisfied this cycle
- alloc_tags  out  ALLOC_LANES*PR_ADDR_W  tag for lane i at [i*PR_ADDR_W +: PR_ADDR_W]
- free_valid  in  FREE_LANES  per-lane release strobe
- free_tags  in  FREE_LANES*PR_ADDR_W  tags released
- flush_valid  in  1  pipeline flush
- flush_mask  in  PHYS_REGS  tags allocated past the flush point, returned to the pool
- free_count  out  PR_ADDR_W+1  registered number of free tags
- err  out  1  sticky illegal-release flag (see Optional Feature)

Behaviour:
- State: free_map[PHYS_REGS-1:0] (1 = free) and free_count register.
- Reset (async):
  - free_map = all ones except bits 0..RESERVED-1 = 0.
  - free_count = PHYS_REGS-RESERVED; err = 0.
  - alloc_ready is a function of state, so it is 1 after reset whenever popcount(alloc_req) ≤ PHYS_REGS-RESERVED.
- Tag selection (combinational from registered free_map):
  - Requesting lanes, in ascending lane order, receive the lowest-indexed free tags in ascending order.
  - Non-requesting lanes output tag 0.
  - No tag appears on two lanes.
- alloc_ready = !flush_valid && (free_count ≥ popcount(alloc_req)).
- fire = alloc_valid && alloc_ready.
  - alloc_req = 0 with alloc_valid = 1 fires with no effect.
  - Tags are valid only in the fire cycle.
  - alloc_tags may change while alloc_ready = 0.
- Edge update, applied in this order to the next-state map:
  1. fire: clear the granted bits.
  2. Each free_valid[j]: set bit free_tags[j].
  3. flush_valid: OR in flush_mask with bits 0..RESERVED-1 forced to 0.
  - A released tag becomes allocatable the cycle after release, never in the same cycle (no bypass).
  - Equal tags on two free lanes, or a tag also present in flush_mask, set the bit once.
- free_count_next = popcount(next free_map).
  - Computed from the next-state map, not incrementally, so duplicates cannot corrupt it.
- Illegal releases are ignored; state is unchanged by them:
  - tag < RESERVED;
  - tag already free in the current free_map.
- Flush has priority over allocation: alloc_ready = 0 during flush, so no allocation occurs in a flush cycle.
- Frees in a flush cycle are still applied.
- Empty pool: alloc_ready = 0 for any nonzero request; a zero-request group still fires.
- Full pool: frees of already-free tags are illegal and ignored.

Optional Feature:
- Macro PRA_CHECK_EN.
- Defined:
  - err sets on any illegal release and stays set until rst.
  - Simulation $error on illegal release, and on flush_mask containing a currently-free tag.
- Undefined:
  - err tied to 0; no checks.
  - Allocation and free behaviour is identical in both builds.

Decomposition:
- constants.vh (existing shared header) gains PR_RESERVED and ALLOC_LANES defaults next to PHYS_REGS / PR_ADDR_W.
- One sub-module: prio_pick_n, which returns the N lowest set bits of a vector as one-hot masks plus encoded indices.
  - Used for tag selection.
  - Reusable by the issue queue.

Test Plan:
- Reset, PHYS_REGS=64, RESERVED=2, alloc_req=3'b111 valid → tags 2,3,4; next cycle free_count=59.
- alloc_req=3'b101 after the above → lane0=5, lane1=0, lane2=6; free_count=57.
- Drain to free_count=1, alloc_req=3'b011 → alloc_ready=0, no state change; alloc_req=3'b001 → fires, free_count=0.
- free_valid=3'b011, tags 10,10 (10 allocated) → free_count +1 only; tag 10 not allocated that cycle, granted the next cycle.
- flush_valid with flush_mask bits 2..6 set and alloc_valid=1 → alloc_ready=0, free_count +5; reserved bits in mask ignored.
- With PRA_CHECK_EN, free tag 1, then free an already-free tag → err=1, free_count unchanged, err held until rst; async rst mid-cycle → outputs at reset values immediately.

Source files
------------

// File: rtl/phys_reg_allocator_pkg.sv
// Shared defaults for the rename-stage physical register free list.
// Holds the register-file geometry and lane counts so the decoder, the
// allocator and the issue queue agree on tag width and reserved tags.
package phys_reg_allocator_pkg;

  // Total physical registers (power of two, >= 8) and the matching tag width.
  localparam int unsigned DEF_PHYS_REGS   = 64;
  localparam int unsigned DEF_PR_ADDR_W   = 6;
  // Tags below this value are hard-wired constant/zero registers.
  localparam int unsigned DEF_PR_RESERVED = 2;
  // One allocation lane per decoder pipeline, one release lane per retire slot.
  localparam int unsigned DEF_ALLOC_LANES = 3;
  localparam int unsigned DEF_FREE_LANES  = 3;

endpackage

// File: rtl/prio_pick_n.sv
// prio_pick_n: returns the N lowest set bits of a vector.
//   vec     - candidate bit vector
//   onehot  - pick k as a one-hot mask at [k*W +: W]
//   idx     - pick k as an encoded index at [k*IW +: IW]
//   found   - found[k] is 1 when vec holds at least k+1 set bits
// Picks are in ascending bit order; picks that do not exist read as zero.
module prio_pick_n #(
  parameter int unsigned W  = 64,
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 6
) (
  input  logic [W-1:0]    vec,
  output logic [N*W-1:0]  onehot,
  output logic [N*IW-1:0] idx,
  output logic [N-1:0]    found
);

  logic [W-1:0] remain;
  logic         hit;

  // Each pick takes the lowest remaining bit, then removes it before the next.
  always_comb begin
    remain = vec;
    hit    = 1'b0;
    onehot = '0;
    idx    = '0;
    found  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      hit = 1'b0;
      for (int unsigned b = 0; b < W; b++) begin
        if (remain[b] && !hit) begin
          hit                 = 1'b1;
          onehot[k*W + b]     = 1'b1;
          idx[k*IW +: IW]     = IW'(b);
        end
      end
      found[k] = hit;
      remain   = remain & ~onehot[k*W +: W];
    end
  end

endmodule

// File: rtl/phys_reg_allocator.sv
// phys_reg_allocator: physical-register free list for the rename stage.
//   clk, rst     - clock, asynchronous active-high reset
//   alloc_req    - per-lane request mask (one tag per set lane)
//   alloc_valid  - request group valid; fires when alloc_ready is also high
//   alloc_ready  - whole group can be satisfied (all-or-nothing)
//   alloc_tags   - tag for lane i at [i*PR_ADDR_W +: PR_ADDR_W], 0 if not requested
//   free_valid   - per-lane release strobe, free_tags holds the released tags
//   flush_valid  - pipeline flush, flush_mask tags return to the pool
//   free_count   - registered number of free tags
//   err          - sticky illegal-release flag
// Build option: define PRA_CHECK_EN to enable err and simulation checks on
// illegal releases and on flushes that name an already-free tag; otherwise
// err is tied low. Allocation and release behaviour is the same either way.
module phys_reg_allocator
  import phys_reg_allocator_pkg::*;
#(
  parameter int unsigned PHYS_REGS   = DEF_PHYS_REGS,
  parameter int unsigned PR_ADDR_W   = DEF_PR_ADDR_W,
  parameter int unsigned RESERVED    = DEF_PR_RESERVED,
  parameter int unsigned ALLOC_LANES = DEF_ALLOC_LANES,
  parameter int unsigned FREE_LANES  = DEF_FREE_LANES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ALLOC_LANES-1:0]           alloc_req,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  output logic [ALLOC_LANES*PR_ADDR_W-1:0] alloc_tags,
  input  logic [FREE_LANES-1:0]            free_valid,
  input  logic [FREE_LANES*PR_ADDR_W-1:0]  free_tags,
  input  logic                             flush_valid,
  input  logic [PHYS_REGS-1:0]             flush_mask,
  output logic [PR_ADDR_W:0]               free_count,
  output logic                             err
);

  localparam int unsigned CNT_W = PR_ADDR_W + 1;
  localparam logic [PHYS_REGS-1:0] ONE      = 1;
  localparam logic [PHYS_REGS-1:0] RES_MASK = (ONE << RESERVED) - ONE;

  if (PR_ADDR_W != $clog2(PHYS_REGS)) begin : g_bad_width
    $error("phys_reg_allocator: PR_ADDR_W must equal clog2(PHYS_REGS)");
  end

  logic [PHYS_REGS-1:0]             free_map;
  logic [PHYS_REGS-1:0]             map_next;
  logic [CNT_W-1:0]                 count_next;
  logic [ALLOC_LANES*PHYS_REGS-1:0] pick_onehot;
  logic [ALLOC_LANES*PR_ADDR_W-1:0] pick_idx;
  logic [ALLOC_LANES-1:0]           pick_found;
  logic [PHYS_REGS-1:0]             grant_mask;
  logic [CNT_W-1:0]                 req_cnt;
  logic                             fire;
  logic                             illegal;

  prio_pick_n #(
    .W  (PHYS_REGS),
    .N  (ALLOC_LANES),
    .IW (PR_ADDR_W)
  ) u_pick (
    .vec    (free_map),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Requesting lanes consume picks in lane order, so the k-th requesting lane
  // takes the k-th lowest free tag.
  always_comb begin
    int unsigned rank;
    rank       = 0;
    alloc_tags = '0;
    grant_mask = '0;
    for (int unsigned i = 0; i < ALLOC_LANES; i++) begin
      if (alloc_req[i]) begin
        alloc_tags[i*PR_ADDR_W +: PR_ADDR_W] = pick_idx[rank*PR_ADDR_W +: PR_ADDR_W];
        if (pick_found[rank]) begin
          grant_mask = grant_mask | pick_onehot[rank*PHYS_REGS +: PHYS_REGS];
        end
        rank = rank + 1;
      end
    end
    req_cnt = CNT_W'(rank);
  end

  assign alloc_ready = !flush_valid && (free_count >= req_cnt);
  assign fire        = alloc_valid && alloc_ready;

  // Legality is judged against the current map, so a tag released this
  // cycle only becomes allocatable next cycle. The count is recomputed from
  // the resulting map so duplicate releases cannot skew it.
  always_comb begin
    map_next = free_map;
    illegal  = 1'b0;
    if (fire) begin
      map_next = map_next & ~grant_mask;
    end
    for (int unsigned j = 0; j < FREE_LANES; j++) begin
      if (free_valid[j]) begin
        if (RES_MASK[free_tags[j*PR_ADDR_W +: PR_ADDR_W]] ||
            free_map[free_tags[j*PR_ADDR_W +: PR_ADDR_W]]) begin
          illegal = 1'b1;
        end else begin
          map_next[free_tags[j*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
        end
      end
    end
    if (flush_valid) begin
      map_next = map_next | (flush_mask & ~RES_MASK);
    end
    count_next = '0;
    for (int unsigned b = 0; b < PHYS_REGS; b++) begin
      count_next = count_next + CNT_W'(map_next[b]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map   <= ~RES_MASK;
      free_count <= CNT_W'(PHYS_REGS - RESERVED);
    end else begin
      free_map   <= map_next;
      free_count <= count_next;
    end
  end

`ifdef PRA_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      if (illegal) begin
        err <= 1'b1;
      end
      assert (!illegal)
        else $error("phys_reg_allocator: release of reserved or already-free tag");
      assert (!(flush_valid && |(flush_mask & free_map & ~RES_MASK)))
        else $error("phys_reg_allocator: flush_mask names an already-free tag");
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Self-checking bench for phys_reg_allocator with default geometry
// (64 registers, 2 reserved, 3 allocation and 3 release lanes).
// Reference model: an array of free flags, scanned for the lowest free tags.
module tb_phys_reg_allocator;

  localparam int NP   = 64;
  localparam int AW   = 6;
  localparam int NL   = 3;
  localparam int NF   = 3;
  localparam int NRES = 2;

  logic               clk;
  logic               rst;
  logic [NL-1:0]      alloc_req;
  logic               alloc_valid;
  logic               alloc_ready;
  logic [NL*AW-1:0]   alloc_tags;
  logic [NF-1:0]      free_valid;
  logic [NF*AW-1:0]   free_tags;
  logic               flush_valid;
  logic [NP-1:0]      flush_mask;
  logic [AW:0]        free_count;
  logic               err;

  phys_reg_allocator #(
    .PHYS_REGS   (NP),
    .PR_ADDR_W   (AW),
    .RESERVED    (NRES),
    .ALLOC_LANES (NL),
    .FREE_LANES  (NF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_tags  (alloc_tags),
    .free_valid  (free_valid),
    .free_tags   (free_tags),
    .flush_valid (flush_valid),
    .flush_mask  (flush_mask),
    .free_count  (free_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit mfree[NP];
  bit merr;

  function automatic int mcount();
    int n = 0;
    for (int b = 0; b < NP; b++) n += int'(mfree[b]);
    return n;
  endfunction

  function automatic bit check_en();
`ifdef PRA_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NP; b++) mfree[b] = (b >= NRES);
    merr = 1'b0;
  endtask

  // Expected tags and readiness for the inputs currently driven.
  task automatic model_expect(output logic [NL*AW-1:0] tags, output logic rdy);
    int pos = 0;
    int need = 0;
    tags = '0;
    for (int l = 0; l < NL; l++) need += int'(alloc_req[l]);
    rdy = !flush_valid && (mcount() >= need);
    for (int l = 0; l < NL; l++) begin
      if (alloc_req[l]) begin
        while (pos < NP && !mfree[pos]) pos++;
        if (pos < NP) tags[l*AW +: AW] = AW'(pos);
        pos++;
      end
    end
  endtask

  task automatic model_commit();
    logic [NL*AW-1:0] t;
    logic r;
    bit nxt[NP];
    model_expect(t, r);
    nxt = mfree;
    if (alloc_valid && r) begin
      for (int l = 0; l < NL; l++) if (alloc_req[l]) nxt[t[l*AW +: AW]] = 1'b0;
    end
    for (int j = 0; j < NF; j++) begin
      if (free_valid[j]) begin
        int tg = int'(free_tags[j*AW +: AW]);
        if (tg >= NRES && !mfree[tg]) nxt[tg] = 1'b1;
        else merr = check_en();
      end
    end
    if (flush_valid) begin
      for (int b = NRES; b < NP; b++) if (flush_mask[b]) nxt[b] = 1'b1;
    end
    mfree = nxt;
  endtask

  task automatic idle_inputs();
    alloc_req   = '0;
    alloc_valid = 1'b0;
    free_valid  = '0;
    free_tags   = '0;
    flush_valid = 1'b0;
    flush_mask  = '0;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (free_count !== 7'd62) begin
      errors++; $display("FAIL reset_count: got %0d expected 62", free_count);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %0b expected 0", err);
    end
    alloc_req = 3'b111;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b expected 1", alloc_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_alloc_order();
    alloc_req = 3'b111; alloc_valid = 1'b1;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tags !== {6'd4, 6'd3, 6'd2}) begin
      errors++; $display("FAIL alloc_111: got ready=%0b tags=%h expected ready=1 tags=%h",
                         alloc_ready, alloc_tags, {6'd4, 6'd3, 6'd2});
    end
    tick();
    checks++;
    if (free_count !== 7'd59) begin
      errors++; $display("FAIL count_59: got %0d expected 59", free_count);
    end
    alloc_req = 3'b101;
    #1;
    checks++;
    if (alloc_tags !== {6'd6, 6'd0, 6'd5}) begin
      errors++; $display("FAIL alloc_101: got %h expected %h", alloc_tags, {6'd6, 6'd0, 6'd5});
    end
    tick();
    checks++;
    if (free_count !== 7'd57) begin
      errors++; $display("FAIL count_57: got %0d expected 57", free_count);
    end
  endtask

  task automatic test_drain();
    alloc_valid = 1'b1;
    alloc_req   = 3'b111;
    for (int i = 0; i < 18; i++) tick();
    alloc_req = 3'b011;
    tick();
    checks++;
    if (free_count !== 7'd1) begin
      errors++; $display("FAIL drain_count: got %0d expected 1", free_count);
    end
    alloc_req = 3'b011;
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL short_pool_ready: got %0b expected 0", alloc_ready);
    end
    tick();
    checks++;
    if (free_count !== 7'd1) begin
      errors++; $display("FAIL short_pool_hold: got %0d expected 1", free_count);
    end
    alloc_req = 3'b001;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tags[AW-1:0] !== 6'd63) begin
      errors++; $display("FAIL last_tag: got ready=%0b tag=%0d expected ready=1 tag=63",
                         alloc_ready, alloc_tags[AW-1:0]);
    end
    tick();
    checks++;
    if (free_count !== 7'd0) begin
      errors++; $display("FAIL empty_count: got %0d expected 0", free_count);
    end
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL empty_ready: got %0b expected 0", alloc_ready);
    end
    alloc_req = 3'b000;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL empty_zero_req: got %0b expected 1", alloc_ready);
    end
    tick();
  endtask

  task automatic test_dup_free();
    alloc_valid = 1'b1;
    alloc_req   = 3'b001;
    free_valid  = 3'b011;
    free_tags   = {6'd0, 6'd10, 6'd10};
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL no_bypass_ready: got %0b expected 0", alloc_ready);
    end
    tick();
    checks++;
    if (free_count !== 7'd1) begin
      errors++; $display("FAIL dup_free_count: got %0d expected 1", free_count);
    end
    free_valid = '0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tags[AW-1:0] !== 6'd10) begin
      errors++; $display("FAIL regrant_10: got ready=%0b tag=%0d expected ready=1 tag=10",
                         alloc_ready, alloc_tags[AW-1:0]);
    end
    tick();
    checks++;
    if (free_count !== 7'd0) begin
      errors++; $display("FAIL regrant_count: got %0d expected 0", free_count);
    end
  endtask

  task automatic test_flush();
    alloc_valid = 1'b1;
    alloc_req   = 3'b111;
    flush_valid = 1'b1;
    flush_mask  = 64'h7F;
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %0b expected 0", alloc_ready);
    end
    tick();
    checks++;
    if (free_count !== 7'd5) begin
      errors++; $display("FAIL flush_count: got %0d expected 5", free_count);
    end
    flush_valid = 1'b0;
    flush_mask  = '0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tags !== {6'd4, 6'd3, 6'd2}) begin
      errors++; $display("FAIL post_flush_tags: got ready=%0b tags=%h expected ready=1 tags=%h",
                         alloc_ready, alloc_tags, {6'd4, 6'd3, 6'd2});
    end
    tick();
    checks++;
    if (free_count !== 7'd2) begin
      errors++; $display("FAIL post_flush_count: got %0d expected 2", free_count);
    end
  endtask

  task automatic test_illegal_free();
    idle_inputs();
    free_valid = 3'b011;
    free_tags  = {6'd0, 6'd5, 6'd1};
    tick();
    checks++;
    if (free_count !== 7'd2) begin
      errors++; $display("FAIL illegal_count: got %0d expected 2", free_count);
    end
    idle_inputs();
    tick();
    checks++;
    if (err !== check_en()) begin
      errors++; $display("FAIL illegal_err: got %0b expected %0b", err, check_en());
    end
  endtask

  function automatic logic [AW-1:0] pick_release();
    int start = int'($urandom_range(0, NP-1));
    if ($urandom_range(0, 4) == 0) return AW'(start);
    for (int i = 0; i < NP; i++) begin
      int t = (start + i) % NP;
      if (t >= NRES && !mfree[t]) return AW'(t);
    end
    return AW'(start);
  endfunction

  task automatic test_random();
    logic [NL*AW-1:0] et;
    logic             er;
    for (int n = 0; n < 400; n++) begin
      alloc_req   = NL'($urandom);
      alloc_valid = ($urandom_range(0, 3) != 0);
      free_valid  = NF'($urandom);
      for (int j = 0; j < NF; j++) free_tags[j*AW +: AW] = pick_release();
      flush_valid = ($urandom_range(0, 24) == 0);
      flush_mask  = {$urandom, $urandom};
      #1;
      model_expect(et, er);
      checks++;
      if (alloc_ready !== er) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", n, alloc_ready, er);
      end
      if (er) begin
        checks++;
        if (alloc_tags !== et) begin
          errors++; $display("FAIL rnd_tags[%0d]: got %h expected %h", n, alloc_tags, et);
        end
      end
      tick();
      checks++;
      if (free_count !== (AW+1)'(mcount())) begin
        errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, free_count, mcount());
      end
      checks++;
      if (err !== merr) begin
        errors++; $display("FAIL rnd_err[%0d]: got %0b expected %0b", n, err, merr);
      end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    alloc_valid = 1'b1;
    alloc_req   = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (free_count !== 7'd62 || err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got count=%0d err=%0b expected count=62 err=0",
                         free_count, err);
    end
    checks++;
    if (alloc_tags !== {6'd4, 6'd3, 6'd2}) begin
      errors++; $display("FAIL async_reset_tags: got %h expected %h", alloc_tags, {6'd4, 6'd3, 6'd2});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc_order();
    test_drain();
    test_dup_free();
    test_flush();
    test_illegal_free();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
